// File: rtl/ds18b20_pkg.sv
// DS18B20 sequencer shared definitions: engine opcodes, DS18B20
// command bytes, FSM state and step encodings, step-to-command map.
package ds18b20_pkg;

    localparam logic [1:0] OP_BUS_RESET  = 2'd0;
    localparam logic [1:0] OP_WRITE_BYTE = 2'd1;
    localparam logic [1:0] OP_READ_BYTE  = 2'd2;

    localparam logic [7:0] SKIP_ROM     = 8'hCC;
    localparam logic [7:0] CONVERT_T    = 8'h44;
    localparam logic [7:0] READ_SCRATCH = 8'hBE;

    localparam int SCRATCH_LEN = 9;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_ISSUE = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_CONV  = 3'd3;
    localparam state_t S_CHECK = 3'd4;

    typedef logic [3:0] step_t;
    localparam step_t ST_RESET1 = 4'd0;
    localparam step_t ST_SKIP1  = 4'd1;
    localparam step_t ST_CONVT  = 4'd2;
    localparam step_t ST_CWAIT  = 4'd3;
    localparam step_t ST_RESET2 = 4'd4;
    localparam step_t ST_SKIP2  = 4'd5;
    localparam step_t ST_RDSCR  = 4'd6;
    localparam step_t ST_READ   = 4'd7;
    localparam step_t ST_CHECK  = 4'd8;

    // {op, data} issued for a bus step
    function automatic logic [9:0] step_cmd(input step_t s);
        logic [9:0] c;
        case (s)
            ST_SKIP1, ST_SKIP2: c = {OP_WRITE_BYTE, SKIP_ROM};
            ST_CONVT:           c = {OP_WRITE_BYTE, CONVERT_T};
            ST_RDSCR:           c = {OP_WRITE_BYTE, READ_SCRATCH};
            ST_READ:            c = {OP_READ_BYTE, 8'h00};
            default:            c = {OP_BUS_RESET, 8'h00};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ds18b20_if.sv
// Command/response link between the sequencer (master) and the
// byte-level 1-wire engine (slave): cmd valid/ready, rsp pulse.
interface ds18b20_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_presence;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_presence
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_presence
    );

endinterface

// File: rtl/crc8_maxim.sv
// Byte-wide Maxim CRC8 update (reflected poly 0x8C, LSB first).
// Ports: i_crc_in current CRC, i_data byte, o_crc_out next CRC.
module crc8_maxim (
    input  logic [7:0] i_crc_in,
    input  logic [7:0] i_data,
    output logic [7:0] o_crc_out
);

    logic [7:0] w_c;

    always_comb begin
        w_c = i_crc_in;
        for (int i = 0; i < 8; i++) begin
            if (w_c[0] ^ i_data[i])
                w_c = (w_c >> 1) ^ 8'h8C;
            else
                w_c = w_c >> 1;
        end
        o_crc_out = w_c;
    end

endmodule

// File: rtl/ds18b20_sequencer.sv
// DS18B20 measurement sequencer: reset/skip/convert/wait, then
// reset/skip/read-scratchpad/9 reads with CRC check.
// Ports: clk, rst (sync, high), i_start pulse, i_auto_en level,
// bus (engine master), o_temperature raw word, o_temp_valid pulse,
// sticky o_crc_err/o_no_presence/o_timeout, o_busy.
module ds18b20_sequencer
    import ds18b20_pkg::*;
#(
    parameter int unsigned CONV_WAIT_CYC   = 750000,
    parameter int unsigned PERIOD_CYC      = 1000000,
    parameter int unsigned RSP_TIMEOUT_CYC = 20000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_auto_en,
    ds18b20_if.master         bus,
    output logic [15:0]       o_temperature,
    output logic              o_temp_valid,
    output logic              o_crc_err,
    output logic              o_no_presence,
    output logic              o_timeout,
    output logic              o_busy
);

    localparam int CW = $clog2(CONV_WAIT_CYC + 1);
    localparam int PW = $clog2(PERIOD_CYC + 1);
    localparam int TW = $clog2(RSP_TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] C_LAST = CW'(CONV_WAIT_CYC - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] T_LAST = TW'(RSP_TIMEOUT_CYC - 1);
    localparam logic [3:0]    B_LAST = 4'(SCRATCH_LEN - 1);

    state_t        r_state;
    step_t         r_step;
    logic [3:0]    r_byte;
    logic [7:0]    r_crc;
    logic          r_nz;
    logic [15:0]   r_shadow;
    logic [CW-1:0] r_conv;
    logic [PW-1:0] r_period;
    logic [TW-1:0] r_tmo;
    logic [15:0]   r_temp;
    logic          r_tv;
    logic          r_crc_err;
    logic          r_nop;
    logic          r_tmo_flag;

    logic [7:0]    w_crc_next;
    logic [9:0]    w_cmd;
    logic          w_fire;
    logic          w_go;
    logic          w_is_reset;
    logic          w_tmo_hit;
    logic          w_pass;

    crc8_maxim u_crc (
        .i_crc_in  (r_crc),
        .i_data    (bus.rsp_data),
        .o_crc_out (w_crc_next)
    );

    assign w_cmd      = step_cmd(r_step);
    assign w_fire     = i_auto_en && (r_period == P_LAST);
    assign w_go       = i_start || w_fire;
    assign w_is_reset = (r_step == ST_RESET1) || (r_step == ST_RESET2);
    assign w_tmo_hit  = (r_tmo == T_LAST);
    // all-zero scratchpad also has CRC 0; reject it as a dead bus
    assign w_pass     = (r_crc == 8'h00) && r_nz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_step     <= ST_RESET1;
            r_byte     <= '0;
            r_crc      <= '0;
            r_nz       <= 1'b0;
            r_shadow   <= '0;
            r_conv     <= '0;
            r_period   <= '0;
            r_tmo      <= '0;
            r_temp     <= '0;
            r_tv       <= 1'b0;
            r_crc_err  <= 1'b0;
            r_nop      <= 1'b0;
            r_tmo_flag <= 1'b0;
        end else begin
            r_tv <= 1'b0;
            if (r_state == S_IDLE && i_auto_en && !w_go)
                r_period <= r_period + 1'b1;
            else
                r_period <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state <= S_ISSUE;
                        r_step  <= ST_RESET1;
                        r_tmo   <= '0;
                        r_byte  <= '0;
                        r_crc   <= '0;
                        r_nz    <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (bus.cmd_ready) begin
                        r_state <= S_WAIT;
                        r_tmo   <= '0;
                    end else if (w_tmo_hit) begin
                        r_tmo_flag <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_WAIT: begin
                    r_tmo <= '0;
                    if (bus.rsp_valid) begin
                        unique case (1'b1)
                            w_is_reset && !bus.rsp_presence: begin
                                r_nop   <= 1'b1;
                                r_state <= S_IDLE;
                            end
                            r_step == ST_CONVT: begin
                                r_step  <= ST_CWAIT;
                                r_conv  <= '0;
                                r_state <= S_CONV;
                            end
                            r_step == ST_READ: begin
                                r_crc <= w_crc_next;
                                r_nz  <= r_nz | (|bus.rsp_data);
                                if (r_byte == 4'd0)
                                    r_shadow[7:0] <= bus.rsp_data;
                                if (r_byte == 4'd1)
                                    r_shadow[15:8] <= bus.rsp_data;
                                if (r_byte == B_LAST) begin
                                    r_step  <= ST_CHECK;
                                    r_state <= S_CHECK;
                                end else begin
                                    r_byte  <= r_byte + 1'b1;
                                    r_state <= S_ISSUE;
                                end
                            end
                            default: begin
                                r_step  <= r_step + 1'b1;
                                r_state <= S_ISSUE;
                            end
                        endcase
                    end else if (w_tmo_hit) begin
                        r_tmo_flag <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_CONV: begin
                    if (r_conv == C_LAST) begin
                        r_step  <= ST_RESET2;
                        r_tmo   <= '0;
                        r_state <= S_ISSUE;
                    end else begin
                        r_conv <= r_conv + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_pass) begin
                        r_temp     <= r_shadow;
                        r_tv       <= 1'b1;
                        r_crc_err  <= 1'b0;
                        r_nop      <= 1'b0;
                        r_tmo_flag <= 1'b0;
                    end else begin
                        r_crc_err <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_valid = (r_state == S_ISSUE);
    assign bus.cmd_op    = bus.cmd_valid ? w_cmd[9:8] : 2'd0;
    assign bus.cmd_data  = bus.cmd_valid ? w_cmd[7:0] : 8'h00;

    assign o_temperature = r_temp;
    assign o_temp_valid  = r_tv;
    assign o_crc_err     = r_crc_err;
    assign o_no_presence = r_nop;
    assign o_timeout     = r_tmo_flag;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ds18b20_sequencer.sv
// Bench for ds18b20_sequencer: engine model on the bus interface,
// command and temperature scoreboards, one task per scenario.
module tb_ds18b20_sequencer;
    import ds18b20_pkg::*;

    localparam int CONV = 10;
    localparam int PER  = 100;
    localparam int TMO  = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic [15:0] temperature;
    logic        temp_valid, crc_err, no_presence, timeout, busy;

    ds18b20_if bus();

    ds18b20_sequencer #(
        .CONV_WAIT_CYC   (CONV),
        .PERIOD_CYC      (PER),
        .RSP_TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (start),
        .i_auto_en     (auto_en),
        .bus           (bus),
        .o_temperature (temperature),
        .o_temp_valid  (temp_valid),
        .o_crc_err     (crc_err),
        .o_no_presence (no_presence),
        .o_timeout     (timeout),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0]  exp_cmd_q[$];
    logic [15:0] exp_temp_q[$];
    logic [7:0]  scratch[9];

    bit         eng_presence = 1'b1;
    bit         eng_drop_read = 1'b0;
    bit         eng_busy = 1'b0;
    int         eng_cnt = 0;
    logic [1:0] eng_op = 2'd0;
    logic [7:0] eng_data = 8'h00;
    int         hold_next = 0;
    int         hold_cnt = 0;
    int         rd_idx = 0;
    int         cyc = 0;
    int         n_acc = 0;
    int         n_reads = 0;
    int         last44 = -1;
    int         conv_gap = -1;
    int         drop_cyc = -1;
    int         tmo_cyc = -1;
    int         tv_count = 0;
    int         busy_fall = -1;
    int         idle_gap = -1;
    bit         prev_busy = 1'b0;

    // engine model and monitors, all on the falling edge
    always @(negedge clk) begin
        logic [9:0] e;
        cyc++;
        bus.rsp_valid = 1'b0;
        if (rst) begin
            eng_busy = 1'b0;
            hold_cnt = 0;
        end
        if (eng_busy) begin
            if (eng_cnt > 0) begin
                eng_cnt--;
            end else begin
                eng_busy = 1'b0;
                if (!(eng_drop_read && eng_op == OP_READ_BYTE)) begin
                    bus.rsp_valid    = 1'b1;
                    bus.rsp_presence = eng_presence;
                    bus.rsp_data     = 8'h00;
                    if (eng_op == OP_READ_BYTE && rd_idx < 9) begin
                        bus.rsp_data = scratch[rd_idx];
                        rd_idx++;
                    end
                    if (eng_op == OP_WRITE_BYTE && eng_data == CONVERT_T)
                        last44 = cyc;
                end
            end
        end else if (hold_cnt > 0) begin
            hold_cnt--;
        end
        bus.cmd_ready = !eng_busy && (hold_cnt == 0);

        if (bus.cmd_valid && bus.cmd_ready) begin
            n_acc++;
            n_checks++;
            if (exp_cmd_q.size() == 0) begin
                n_fail++;
                $display("FAIL cmd_unexpected got op=%0d data=%02h",
                         bus.cmd_op, bus.cmd_data);
            end else begin
                e = exp_cmd_q.pop_front();
                if (bus.cmd_op !== e[9:8] ||
                    (e[9:8] == OP_WRITE_BYTE && bus.cmd_data !== e[7:0])) begin
                    n_fail++;
                    $display("FAIL cmd_seq got op=%0d data=%02h want op=%0d data=%02h",
                             bus.cmd_op, bus.cmd_data, e[9:8], e[7:0]);
                end
            end
            if (bus.cmd_op == OP_BUS_RESET) begin
                rd_idx = 0;
                if (last44 >= 0) begin
                    conv_gap = cyc - last44;
                    last44 = -1;
                end
            end
            if (bus.cmd_op == OP_READ_BYTE) begin
                n_reads++;
                if (eng_drop_read) drop_cyc = cyc;
            end
            eng_busy = 1'b1;
            eng_cnt  = 2;
            eng_op   = bus.cmd_op;
            eng_data = bus.cmd_data;
            if (hold_next > 0) begin
                hold_cnt  = hold_next;
                hold_next = 0;
            end
        end

        if (timeout && tmo_cyc < 0 && drop_cyc >= 0)
            tmo_cyc = cyc;

        if (temp_valid === 1'b1) begin
            tv_count++;
            n_checks++;
            if (exp_temp_q.size() == 0) begin
                n_fail++;
                $display("FAIL temp_unexpected got=%04h", temperature);
            end else begin
                logic [15:0] t;
                t = exp_temp_q.pop_front();
                if (temperature !== t) begin
                    n_fail++;
                    $display("FAIL temp_value got=%04h want=%04h", temperature, t);
                end
            end
        end

        if (prev_busy && !busy) busy_fall = cyc;
        if (!prev_busy && busy === 1'b1 && busy_fall >= 0)
            idle_gap = cyc - busy_fall;
        prev_busy = (busy === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic push_seq();
        exp_cmd_q.push_back({OP_BUS_RESET, 8'h00});
        exp_cmd_q.push_back({OP_WRITE_BYTE, SKIP_ROM});
        exp_cmd_q.push_back({OP_WRITE_BYTE, CONVERT_T});
        exp_cmd_q.push_back({OP_BUS_RESET, 8'h00});
        exp_cmd_q.push_back({OP_WRITE_BYTE, SKIP_ROM});
        exp_cmd_q.push_back({OP_WRITE_BYTE, READ_SCRATCH});
        for (int i = 0; i < 9; i++)
            exp_cmd_q.push_back({OP_READ_BYTE, 8'h00});
    endtask

    task automatic load_scratch(input logic [7:0] last);
        logic [7:0] v[9];
        v = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
        v[8] = last;
        scratch = v;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (busy === 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_busy(input int budget, output bit ok);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (busy === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (temperature !== 16'h0000 || temp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_temp got=%04h tv=%b want=0000 tv=0",
                     temperature, temp_valid);
        end
        n_checks++;
        if ({crc_err, no_presence, timeout} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=000",
                     {crc_err, no_presence, timeout});
        end
        n_checks++;
        if (busy !== 1'b0 || bus.cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got busy=%b cmd_valid=%b want 0 0",
                     busy, bus.cmd_valid);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_crc_err();
        bit ok;
        int tv0;
        load_scratch(8'h1D);
        push_seq();
        tv0 = tv_count;
        conv_gap = -1;
        pulse_start();
        wait_idle(2000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL crc_done busy=%b want=0", busy);
        end
        n_checks++;
        if (crc_err !== 1'b1 || temperature !== 16'h0000) begin
            n_fail++;
            $display("FAIL crc_err got crc_err=%b temp=%04h want 1 0000",
                     crc_err, temperature);
        end
        n_checks++;
        if (tv_count != tv0 || exp_cmd_q.size() != 0) begin
            n_fail++;
            $display("FAIL crc_pulse got tv=%0d left=%0d want 0 0",
                     tv_count - tv0, exp_cmd_q.size());
        end
        n_checks++;
        if (conv_gap != CONV + 1) begin
            n_fail++;
            $display("FAIL conv_wait got=%0d want=%0d", conv_gap, CONV + 1);
        end
        exp_cmd_q.delete();
    endtask

    task automatic test_good();
        bit ok;
        int tv0;
        load_scratch(8'h1C);
        push_seq();
        exp_temp_q.push_back(16'h0550);
        tv0 = tv_count;
        pulse_start();
        wait_idle(2000, ok);
        n_checks++;
        if (!ok || tv_count != tv0 + 1) begin
            n_fail++;
            $display("FAIL good_pulse got done=%b tv=%0d want 1 1",
                     ok, tv_count - tv0);
        end
        n_checks++;
        if (temperature !== 16'h0550) begin
            n_fail++;
            $display("FAIL good_temp got=%04h want=0550", temperature);
        end
        n_checks++;
        if ({crc_err, no_presence, timeout} !== 3'b000) begin
            n_fail++;
            $display("FAIL good_flags got=%b want=000",
                     {crc_err, no_presence, timeout});
        end
        n_checks++;
        if (exp_cmd_q.size() != 0) begin
            n_fail++;
            $display("FAIL good_cmds left=%0d want=0", exp_cmd_q.size());
        end
        exp_cmd_q.delete();
        exp_temp_q.delete();
    endtask

    task automatic test_no_presence();
        bit ok;
        int a0;
        eng_presence = 1'b0;
        exp_cmd_q.push_back({OP_BUS_RESET, 8'h00});
        a0 = n_acc;
        pulse_start();
        wait_idle(500, ok);
        n_checks++;
        if (!ok || no_presence !== 1'b1) begin
            n_fail++;
            $display("FAIL nopres_flag got done=%b np=%b want 1 1", ok, no_presence);
        end
        n_checks++;
        if (n_acc != a0 + 1) begin
            n_fail++;
            $display("FAIL nopres_cmds got=%0d want=1", n_acc - a0);
        end
        n_checks++;
        if (temperature !== 16'h0550) begin
            n_fail++;
            $display("FAIL nopres_temp got=%04h want=0550", temperature);
        end
        eng_presence = 1'b1;
        exp_cmd_q.delete();
    endtask

    task automatic test_timeout();
        bit ok;
        int r0;
        eng_drop_read = 1'b1;
        drop_cyc = -1;
        tmo_cyc  = -1;
        r0 = n_reads;
        push_seq();
        pulse_start();
        wait_idle(3000, ok);
        n_checks++;
        if (!ok || timeout !== 1'b1 || bus.cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_flag got done=%b tmo=%b cv=%b want 1 1 0",
                     ok, timeout, bus.cmd_valid);
        end
        n_checks++;
        if (drop_cyc < 0 || tmo_cyc - drop_cyc != TMO + 1) begin
            n_fail++;
            $display("FAIL tmo_cycles got=%0d want=%0d",
                     tmo_cyc - drop_cyc, TMO + 1);
        end
        n_checks++;
        if (n_reads != r0 + 1 || exp_cmd_q.size() != 8) begin
            n_fail++;
            $display("FAIL tmo_reads got=%0d left=%0d want 1 8",
                     n_reads - r0, exp_cmd_q.size());
        end
        n_checks++;
        if (no_presence !== 1'b1 || temperature !== 16'h0550) begin
            n_fail++;
            $display("FAIL tmo_sticky got np=%b temp=%04h want 1 0550",
                     no_presence, temperature);
        end
        eng_drop_read = 1'b0;
        exp_cmd_q.delete();
    endtask

    task automatic test_hold_ignore();
        bit ok;
        bit stable;
        int a0, tv0, n;
        load_scratch(8'h1C);
        push_seq();
        exp_temp_q.push_back(16'h0550);
        a0 = n_acc;
        tv0 = tv_count;
        hold_next = 50;
        pulse_start();
        n = 0;
        while (n_acc < a0 + 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        while (bus.cmd_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) start = 1'b1;
            if (i == 11) start = 1'b0;
            if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== OP_WRITE_BYTE ||
                bus.cmd_data !== SKIP_ROM)
                stable = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (!stable) begin
            n_fail++;
            $display("FAIL hold_stable got cv=%b op=%0d data=%02h want 1 1 cc",
                     bus.cmd_valid, bus.cmd_op, bus.cmd_data);
        end
        pulse_start();
        wait_idle(3000, ok);
        n_checks++;
        if (!ok || n_acc != a0 + 15 || tv_count != tv0 + 1) begin
            n_fail++;
            $display("FAIL hold_run got cmds=%0d tv=%0d want 15 1",
                     n_acc - a0, tv_count - tv0);
        end
        n_checks++;
        if ({crc_err, no_presence, timeout} !== 3'b000) begin
            n_fail++;
            $display("FAIL hold_clear got=%b want=000",
                     {crc_err, no_presence, timeout});
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || n_acc != a0 + 15) begin
            n_fail++;
            $display("FAIL start_dropped got busy=%b cmds=%0d want 0 15",
                     busy, n_acc - a0);
        end
        exp_cmd_q.delete();
        exp_temp_q.delete();
    endtask

    task automatic test_auto();
        bit ok1, ok2, ok3, ok4;
        int tv0, a0;
        load_scratch(8'h1C);
        push_seq();
        push_seq();
        exp_temp_q.push_back(16'h0550);
        exp_temp_q.push_back(16'h0550);
        tv0 = tv_count;
        @(negedge clk) auto_en = 1'b1;
        wait_busy(PER + 10, ok1);
        wait_idle(2000, ok2);
        idle_gap = -1;
        wait_busy(PER + 10, ok3);
        auto_en = 1'b0;
        wait_idle(2000, ok4);
        n_checks++;
        if (!(ok1 && ok2 && ok3 && ok4)) begin
            n_fail++;
            $display("FAIL auto_runs got %b%b%b%b want 1111", ok1, ok2, ok3, ok4);
        end
        n_checks++;
        if (idle_gap != PER) begin
            n_fail++;
            $display("FAIL auto_period got=%0d want=%0d", idle_gap, PER);
        end
        n_checks++;
        if (tv_count != tv0 + 2 || exp_cmd_q.size() != 0) begin
            n_fail++;
            $display("FAIL auto_count got tv=%0d left=%0d want 2 0",
                     tv_count - tv0, exp_cmd_q.size());
        end
        a0 = n_acc;
        repeat (PER + 20) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || n_acc != a0) begin
            n_fail++;
            $display("FAIL auto_off got busy=%b cmds=%0d want 0 0",
                     busy, n_acc - a0);
        end
        exp_cmd_q.delete();
        exp_temp_q.delete();
    endtask

    task automatic test_reset_mid();
        int r0, tv0, n;
        load_scratch(8'h1C);
        push_seq();
        r0 = n_reads;
        tv0 = tv_count;
        pulse_start();
        n = 0;
        while (n_reads < r0 + 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n_reads < r0 + 3) begin
            n_fail++;
            $display("FAIL rstmid_reach got reads=%0d want>=3", n_reads - r0);
        end
        rst = 1'b1;
        exp_cmd_q.delete();
        @(negedge clk);
        n_checks++;
        if (temperature !== 16'h0000 || busy !== 1'b0 || bus.cmd_valid !== 1'b0 ||
            temp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_out got temp=%04h busy=%b cv=%b tv=%b want 0000 0 0 0",
                     temperature, busy, bus.cmd_valid, temp_valid);
        end
        n_checks++;
        if ({crc_err, no_presence, timeout} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_flags got=%b want=000",
                     {crc_err, no_presence, timeout});
        end
        rst = 1'b0;
        repeat (60) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || tv_count != tv0) begin
            n_fail++;
            $display("FAIL rstmid_after got busy=%b tv=%0d want 0 0",
                     busy, tv_count - tv0);
        end
    endtask

    initial begin
        test_reset();
        test_crc_err();
        test_good();
        test_no_presence();
        test_timeout();
        test_hold_ignore();
        test_auto();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
